// File: rtl/axil_pkg.sv
// Shared AXI4-Lite widths, response codes and channel FSM state types.
package axil_pkg;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_STRB_W = 4;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

endpackage

// File: rtl/axil_aw_w_join.sv
// Captures the AW and W beats independently and reports when both are held.
module axil_aw_w_join
    import axil_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   accept_en,
    input  logic                   clear,
    input  logic [AXIL_ADDR_W-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [AXIL_DATA_W-1:0] wdata,
    input  logic [AXIL_STRB_W-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic                   both_held,
    output logic [AXIL_ADDR_W-1:0] addr,
    output logic [AXIL_DATA_W-1:0] data,
    output logic [AXIL_STRB_W-1:0] strb
);

    logic aw_held;
    logic w_held;

    assign awready   = accept_en && !aw_held;
    assign wready    = accept_en && !w_held;
    assign both_held = aw_held && w_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr    <= '0;
            data    <= '0;
            strb    <= '0;
        end else if (clear) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_held <= 1'b1;
                addr    <= awaddr;
            end
            if (wvalid && wready) begin
                w_held <= 1'b1;
                data   <= wdata;
                strb   <= wstrb;
            end
        end
    end

endmodule

// File: rtl/s_axil_regfile.sv
// AXI4-Lite responder with NUM_REGS 32-bit registers, exported flat on regs_flat.
module s_axil_regfile
    import axil_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              s_axil_awaddr,
    input  logic [2:0]               s_axil_awprot,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [31:0]              s_axil_araddr,
    input  logic [2:0]               s_axil_arprot,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic [NUM_REGS*32-1:0]   regs_flat
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AXIL_ADDR_W-1:0] ADDR_LIMIT = AXIL_ADDR_W'(NUM_REGS * 4);

    logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

    // Handshakes are held off until the first edge after reset release.
    logic live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    logic unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    // ---------------- write channel ----------------
    w_state_t               w_state, w_next;
    logic                   both_held;
    logic                   commit;
    logic                   b_done;
    logic [AXIL_ADDR_W-1:0] wr_addr;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;
    logic                   wr_in_range;
    logic [IDX_W-1:0]       wr_idx;

    assign s_axil_bvalid = (w_state == W_RESP);
    assign b_done        = s_axil_bvalid && s_axil_bready;
    assign wr_in_range   = (wr_addr < ADDR_LIMIT);
    assign wr_idx        = wr_addr[IDX_W+1:2];

    axil_aw_w_join u_join (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept_en (live && (w_state == W_IDLE)),
        .clear     (b_done),
        .awaddr    (s_axil_awaddr),
        .awvalid   (s_axil_awvalid),
        .awready   (s_axil_awready),
        .wdata     (s_axil_wdata),
        .wstrb     (s_axil_wstrb),
        .wvalid    (s_axil_wvalid),
        .wready    (s_axil_wready),
        .both_held (both_held),
        .addr      (wr_addr),
        .data      (wr_data),
        .strb      (wr_strb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: if (both_held) begin
                w_next = W_RESP;
                commit = 1'b1;
            end
            W_RESP: if (s_axil_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      s_axil_bresp <= AXIL_RESP_OKAY;
        else if (commit) s_axil_bresp <= wr_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && wr_in_range) begin
            for (int unsigned b = 0; b < AXIL_STRB_W; b++) begin
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[32*i +: 32] = regs[i];
    end

    // ---------------- read channel ----------------
    r_state_t         r_state, r_next;
    logic             ar_hs;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    assign s_axil_arready = live && (r_state == R_IDLE);
    assign s_axil_rvalid  = (r_state == R_RESP);
    assign ar_hs          = s_axil_arvalid && s_axil_arready;
    assign rd_in_range    = (s_axil_araddr < ADDR_LIMIT);
    assign rd_idx         = s_axil_araddr[IDX_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (s_axil_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Sampling regs here yields the pre-write value on a same-edge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rdata <= '0;
            s_axil_rresp <= AXIL_RESP_OKAY;
        end else if (ar_hs) begin
            s_axil_rdata <= rd_in_range ? regs[rd_idx] : '0;
            s_axil_rresp <= rd_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_s_axil_regfile.sv
// Directed, table-driven bench for s_axil_regfile with hand-written corner sequences.
module tb_s_axil_regfile;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] regs_flat;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [16];

    always #5 clk = ~clk;

    s_axil_regfile #(.NUM_REGS(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .regs_flat      (regs_flat)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_flat(input string name);
        for (int i = 0; i < 16; i++) check(name, regs_flat[32*i +: 32], model[i]);
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (a < 32'h40) begin
            w = model[a[5:2]];
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model[a[5:2]] = w;
        end
    endtask

    // W is presented 'lead' edges before AW; lat counts edges from the last handshake to bvalid.
    task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int lead, output logic [1:0] resp, output int lat, output bit ok);
        int cnt;
        bit aw_done, w_done, aw_hs, w_hs;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        awvalid = (lead == 0);
        aw_done = 0;
        w_done  = 0;
        cnt     = 0;
        while (!(aw_done && w_done) && cnt < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            cnt++;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
            if (!aw_done && !awvalid && cnt >= lead) awvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ok   = aw_done && w_done && bvalid;
        resp = bresp;
        if (ok && bready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                             output bit ok);
        int cnt;
        bit done, hs;
        araddr  = a;
        arvalid = 1'b1;
        cnt     = 0;
        done    = 0;
        while (!done && cnt < 50) begin
            hs = arvalid && arready;
            @(posedge clk); #1;
            cnt++;
            if (hs) done = 1;
        end
        arvalid = 1'b0;
        ok   = done && rvalid;
        d    = rdata;
        resp = rresp;
        if (ok && rready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        bit          ok;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          4'h0,    2'b00, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_003C, 32'h0,          4'h0,    2'b00, 32'h0000_0000};
        vecs[2]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF,  4'hF,    2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,          4'h0,    2'b00, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'h1122_3344,  4'hF,    2'b00, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,          4'h0,    2'b00, 32'h1122_3344};
        vecs[6]  = '{1'b1, 32'h0000_0040, 32'h1234_5678,  4'hF,    2'b10, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0,          4'h0,    2'b10, 32'h0000_0000};
        vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,          4'h0,    2'b10, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D,  4'hF,    2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_003F, 32'h0,          4'h0,    2'b00, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF,  4'b1000, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,          4'h0,    2'b00, 32'hFF00_0000};
        vecs[13] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001,  4'hF,    2'b10, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_003C, 32'h0,          4'h0,    2'b00, 32'hCAFE_F00D};

        for (int i = 0; i < 16; i++) model[i] = '0;

        rst_n   = 1'b0;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready",  wready,  0);
        check("rst_arready", arready, 0);
        check("rst_bvalid",  bvalid,  0);
        check("rst_rvalid",  rvalid,  0);
        check("rst_rdata",   rdata,   0);
        check("rst_bresp",   bresp,   0);
        check("rst_rresp",   rresp,   0);
        check_flat("rst_regs_flat");
        rst_n = 1'b1;
        check("arready_before_edge", arready, 0);
        @(posedge clk); #1;
        check("arready_after_edge", arready, 1);
        check("awready_after_edge", awready, 1);
        check("wready_after_edge",  wready,  1);

        // vector table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                axil_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp, lat, ok);
                check("wr_done", ok, 1);
                check("wr_bresp", resp, vecs[i].resp);
                check("wr_latency", lat, 1);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                check_flat("wr_regs_flat");
            end else begin
                axil_read(vecs[i].addr, d, resp, ok);
                check("rd_done", ok, 1);
                check("rd_rdata", d, vecs[i].rdata);
                check("rd_rresp", resp, vecs[i].resp);
            end
        end

        // W two edges ahead of AW, partial strobe onto 0x11223344
        axil_write(32'h4, 32'hAABB_CCDD, 4'b0101, 2, resp, lat, ok);
        check("wfirst_done", ok, 1);
        check("wfirst_bresp", resp, 2'b00);
        check("wfirst_latency", lat, 1);
        check("wfirst_flat", regs_flat[63:32], 32'h11BB_33DD);
        model[1] = 32'h11BB_33DD;
        axil_read(32'h4, d, resp, ok);
        check("wfirst_rd_done", ok, 1);
        check("wfirst_rdata", d, 32'h11BB_33DD);

        // back-pressure on B while a read proceeds
        bready = 1'b0;
        axil_write(32'h8, 32'h55AA_55AA, 4'hF, 0, resp, lat, ok);
        check("bp_wr_done", ok, 1);
        check("bp_flat", regs_flat[95:64], 32'h55AA_55AA);
        model[2] = 32'h55AA_55AA;
        axil_read(32'h8, d, resp, ok);
        check("bp_rd_done", ok, 1);
        check("bp_rdata", d, 32'h55AA_55AA);
        check("bp_rresp", resp, 2'b00);
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid",  bvalid,  1);
            check("bp_awready", awready, 0);
            check("bp_wready",  wready,  0);
            check("bp_bresp",   bresp,   2'b00);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_bvalid", bvalid, 0);
        check("bp_release_awready", awready, 1);

        // reset between AW and W
        awaddr  = 32'hC;
        awvalid = 1'b1;
        begin
            int  cnt;
            bit  hs, done;
            cnt  = 0;
            done = 0;
            while (!done && cnt < 50) begin
                hs = awvalid && awready;
                @(posedge clk); #1;
                cnt++;
                if (hs) done = 1;
            end
            check("mid_aw_accepted", done, 1);
        end
        awvalid = 1'b0;
        check("mid_aw_held", awready, 0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        check("mid_bvalid",  bvalid,  0);
        check("mid_rvalid",  rvalid,  0);
        check("mid_awready", awready, 0);
        check("mid_wready",  wready,  0);
        check_flat("mid_regs_flat");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_awready_after", awready, 1);
        check("mid_wready_after",  wready,  1);
        check("mid_regs3", regs_flat[127:96], 32'h0);
        axil_write(32'hC, 32'h0BAD_F00D, 4'hF, 0, resp, lat, ok);
        check("mid_wr_done", ok, 1);
        check("mid_wr_bresp", resp, 2'b00);
        check("mid_wr_latency", lat, 1);
        model[3] = 32'h0BAD_F00D;
        check_flat("mid_wr_flat");
        axil_read(32'hC, d, resp, ok);
        check("mid_rd_done", ok, 1);
        check("mid_rdata", d, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_axil_regfile.md
# s_axil_regfile

AXI4-Lite responder (slave) holding `NUM_REGS` 32-bit read/write registers. It is the far end of the AXI-Lite master adapter path, so simulations get a real target to issue writes and reads against. Register contents are also exported in parallel so other blocks can consume the configuration. There is one outstanding write and one outstanding read at a time. The read and write channels operate independently.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers. Range 1..256.
- `IDX_W`, `$clog2(NUM_REGS)` (min 1): word index width. Derived, not overridden.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_axil_awaddr`, in, 32 / `s_axil_awprot`, in, 3 (ignored) / `s_axil_awvalid`, in, 1 / `s_axil_awready`, out, 1.
- `s_axil_wdata`, in, 32 / `s_axil_wstrb`, in, 4 / `s_axil_wvalid`, in, 1 / `s_axil_wready`, out, 1.
- `s_axil_bresp`, out, 2 / `s_axil_bvalid`, out, 1 / `s_axil_bready`, in, 1.
- `s_axil_araddr`, in, 32 / `s_axil_arprot`, in, 3 (ignored) / `s_axil_arvalid`, in, 1 / `s_axil_arready`, out, 1.
- `s_axil_rdata`, out, 32 / `s_axil_rresp`, out, 2 / `s_axil_rvalid`, out, 1 / `s_axil_rready`, in, 1.
- `regs_flat`, out, `NUM_REGS*32`: register i is driven on bits `[32*i+31:32*i]`.

## Operation
- **Address decode:** `addr[1:0]` is ignored. The word index is `addr >> 2`. The address is in range iff `addr < NUM_REGS*4`, compared on all 32 bits.
- **Write channel states:**
  - `W_IDLE`: AW and W are accepted independently, in either order or together. Each accepted beat is latched with a flag `aw_held` / `w_held`.
  - Once both are held, the FSM moves to `W_RESP`. In the transition edge:
    - In range: register byte k is updated iff `wstrb[k]`. BRESP=OKAY (2'b00).
    - Out of range: no register changes. BRESP=SLVERR (2'b10).
  - `W_RESP`: `bvalid=1` until the `bvalid&&bready` handshake, then return to `W_IDLE` and clear both flags.
  - `awready = !aw_held && state==W_IDLE`. `wready = !w_held && state==W_IDLE`.
- **Read channel states:**
  - `R_IDLE`: `arready=1`. On handshake, `rdata` is loaded with `regs[idx]` (or 0 if out of range), `rresp` with OKAY/SLVERR, and `rvalid` is set. Go to `R_RESP`.
  - `R_RESP`: `arready=0`. `rdata`/`rresp` are stable until the `rvalid&&rready` handshake, then return to `R_IDLE`.
- **Write/read collision:** a read handshake in the same edge as a write commit to the same register returns the pre-write value.
- **Stable outputs:** `bresp`, `rdata` and `rresp` must not change while the corresponding valid is high.
- **Reset:** all registers and `regs_flat` = 0. `awready`, `wready`, `bvalid`, `rvalid`, `rdata`, `bresp`, `rresp` = 0. `arready` = 0 during reset and 1 from the first edge after reset release. FSMs enter `W_IDLE` / `R_IDLE` and held flags are cleared.
- **Reset mid-transaction:** the transaction is dropped. No partial write may survive.

## Timing
- **Write:** both AW and W handshaked at edge k → register updated and `bvalid` high after edge k+1.
  - AW at k, W at k+2 → commit and `bvalid` after k+3.
  - Minimum 3 cycles per write with `bready` held high.
- **Read:** AR handshake at edge k → `rvalid` and `rdata` valid after edge k. Minimum 2 cycles per read with `rready` held high.
- **Back-pressure:** `bready`/`rready` low stalls that channel indefinitely. The other channel is unaffected.
- **Register output:** `regs_flat` reflects a committed write in the same cycle `bvalid` rises.

## Structure
- **Package `axil_pkg`:**
  - Response constants `AXIL_RESP_OKAY=2'b00` and `AXIL_RESP_SLVERR=2'b10`.
  - Write FSM enum `{W_IDLE, W_RESP}` and read FSM enum `{R_IDLE, R_RESP}`.
  - `AXIL_DATA_W=32`, `AXIL_ADDR_W=32`, `AXIL_STRB_W=4`.
- **Sub-module `axil_aw_w_join`:** holds the AW/W capture flags, latched address, data and strobe. Outputs `both_held` and clears on `clear`. The top level holds the FSMs, register array and read path.

## Test plan
- **Reset values:** deassert `rst_n`. Then read addr 0x0 → `rdata=0`, OKAY. Read addr `0x3C` → `rdata=0`, OKAY.
- **Basic write/read, same-cycle AW+W:** write 0xDEADBEEF to 0x8 with `wstrb=4'hF` → `bvalid` one cycle later, BRESP=00. Read 0x8 → 0xDEADBEEF, and `regs_flat[95:64]=0xDEADBEEF`.
- **Strobe, W before AW:** preload 0x11223344 at 0x4. Present W=0xAABBCCDD with `wstrb=4'b0101` two cycles before AW to 0x4 → register = 0x11BB33DD.
- **Out of range:** write to 0x40 (NUM_REGS=16) → BRESP=10 and no register changes. Read 0x100 → `rdata=0`, RRESP=10.
- **Back-pressure:** hold `bready=0` for 5 cycles → `bvalid` stays 1, `awready`/`wready` stay 0 and BRESP is stable. Meanwhile a read of 0x8 completes normally.
- **Reset mid-write:** accept AW to 0xC, pulse `rst_n` low before W arrives → `regs[3]=0`, all valids 0, and the next full write succeeds.
